// File: rtl/mcp3_afp_pkg.sv
// Shared AFP command-path types: tag width, tag count and the related typedefs.
package mcp3_afp_pkg;

  localparam int TAG_W    = 4;
  localparam int NUM_TAGS = 16;

  typedef logic [TAG_W-1:0]    tag_t;
  typedef logic [NUM_TAGS-1:0] tag_mask_t;
  // One extra bit so a fully-outstanding count of NUM_TAGS is representable.
  typedef logic [TAG_W:0]      count_t;

endpackage

// File: rtl/mcp3_decoder4x016.sv
// 4-to-16 one-hot decoder used to turn tag numbers into bitmap masks.
module mcp3_decoder4x016
  import mcp3_afp_pkg::*;
(
  input  logic [TAG_W-1:0]    din,
  output logic [NUM_TAGS-1:0] dout
);

  for (genvar gi = 0; gi < NUM_TAGS; gi++) begin : g_dec
    assign dout[gi] = (din == tag_t'(gi));
  end

endmodule

// File: rtl/mcp3_ffs016x4.sv
// Find-lowest-set over a 16-bit vector; idx is 0 when nothing is set.
module mcp3_ffs016x4
  import mcp3_afp_pkg::*;
(
  input  logic [NUM_TAGS-1:0] din,
  output logic [TAG_W-1:0]    idx,
  output logic                found
);

  always_comb begin
    idx   = '0;
    found = |din;
    // Scan downward so the lowest set bit is the last one to win.
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (din[i]) idx = tag_t'(i);
    end
  end

endmodule

// File: rtl/mcp3_tag_alloc16.sv
// 16-entry command-tag allocator: presents the lowest free tag, reclaims returned
// tags, counts outstanding tags and flags frees of tags that are not taken.
module mcp3_tag_alloc16
  import mcp3_afp_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  output logic             tag_valid,
  output logic [TAG_W-1:0] tag,
  input  logic             tag_take,
  input  logic             free_valid,
  input  logic [TAG_W-1:0] free_tag,
  output logic [TAG_W:0]   outstanding,
  output logic             all_idle,
  output logic             free_err
);

  localparam logic [TAG_W+1:0] CAP = (TAG_W + 2)'(MAX_OUTSTANDING);

  tag_mask_t        taken;
  tag_mask_t        taken_next;
  tag_mask_t        free_mask;
  tag_mask_t        tag_mask;
  tag_mask_t        candidates;
  tag_t             cand_idx;
  logic             cand_found;
  logic             take_now;
  logic             free_ok;
  logic             free_bad;
  logic             load;
  logic [TAG_W+1:0] pending;
  count_t           outstanding_next;

  mcp3_decoder4x016 u_free_dec (
    .din  (free_tag),
    .dout (free_mask)
  );

  mcp3_decoder4x016 u_tag_dec (
    .din  (tag),
    .dout (tag_mask)
  );

  // The presented tag is already committed to the output stage, so it is not
  // offered again even though its taken bit is still clear.
  assign candidates = ~taken & ~(tag_valid ? tag_mask : '0);

  mcp3_ffs016x4 u_ffs (
    .din   (candidates),
    .idx   (cand_idx),
    .found (cand_found)
  );

  assign take_now = tag_valid & tag_take;
  assign free_ok  = free_valid & (|(free_mask & taken));
  assign free_bad = free_valid & ~free_ok;
  assign pending  = {1'b0, outstanding} + {{(TAG_W + 1){1'b0}}, take_now};
  assign load     = enable & (~tag_valid | tag_take) & cand_found & (pending < CAP);

  // Take and free never target the same tag: the presented tag is never taken.
  assign taken_next = (taken | (take_now ? tag_mask : '0)) & ~(free_ok ? free_mask : '0);

  always_comb begin
    outstanding_next = outstanding;
    case ({take_now, free_ok})
      2'b10:   outstanding_next = outstanding + count_t'(1);
      2'b01:   outstanding_next = outstanding - count_t'(1);
      default: outstanding_next = outstanding;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      taken       <= '0;
      tag_valid   <= 1'b0;
      tag         <= '0;
      outstanding <= '0;
      all_idle    <= 1'b1;
      free_err    <= 1'b0;
    end else begin
      taken       <= taken_next;
      outstanding <= outstanding_next;
      all_idle    <= (outstanding_next == '0);
      if (free_bad) free_err <= 1'b1;
      if (load) begin
        tag_valid <= 1'b1;
        tag       <= cand_idx;
      end else if (take_now) begin
        tag_valid <= 1'b0;
      end
    end
  end

endmodule
